// File: rtl/raster_pkg.sv
// raster_pkg: shared FSM encoding and descriptor bit positions for the raster job controller.
package raster_pkg;
   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, FLUSH} state_t;
   // ctrl_reg0 field offsets above the vertexSize field (which occupies the low W bits)
   localparam int NO_PERSP_OFS = 7;
   localparam int FLAT_OFS = 6;
   localparam int PROVOKE_OFS = 5;
   localparam int WINDING_OFS = 4;
   localparam int FACE_CULL_OFS = 3;
   localparam int ORIGIN_OFS = 2;
   localparam int MODE_OFS = 0;
   localparam int TRIS_MSB = 15;
   localparam int POLY_BIT = 16;
   localparam int RESX_LSB = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: single-grant round-robin arbiter; the search starts one past the last winner.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);
   localparam int PW = N > 1 ? $clog2(N) : 1;
   logic [PW-1:0] ptr, nxt, idx;
   logic found;
   always_comb begin
      grant = '0;
      nxt = ptr;
      found = 1'b0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant[idx] = 1'b1;
            nxt = PW'((int'(idx) + 1) % N);
         end
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) ptr <= '0;
      else if (found) ptr <= nxt;
endmodule

// File: rtl/raster_job_ctrl.sv
// raster_job_ctrl: sequences one raster job - load balancer launch, round-robin triangle pipe
// starts, drain/abort handling, descriptor registers and performance counters.
module raster_job_ctrl
   import raster_pkg::*;
#(
   parameter int NUM_T_PIPES = 4,
   parameter int LOCAL_VERTEX_MEM_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   abort,
   input  logic                                   en,
   input  logic [DATA_WIDTH-1:0]                  ctrl_reg0,
   input  logic [DATA_WIDTH-1:0]                  ctrl_reg1,
   input  logic [DATA_WIDTH-1:0]                  res_reg,
   input  logic [DATA_WIDTH-1:0]                  i_array_ptr,
   input  logic [DATA_WIDTH-1:0]                  v_array_ptr,
   input  logic [DATA_WIDTH-1:0]                  f_array_ptr,
   input  logic [NUM_T_PIPES-1:0]                 pipe_mask,
   input  logic                                   lb_ready,
   input  logic                                   lb_done,
   input  logic [NUM_T_PIPES-1:0]                 tri_fifo_threshold,
   input  logic [NUM_T_PIPES-1:0]                 tri_fifo_full,
   input  logic [NUM_T_PIPES-1:0]                 tri_fifo_empty,
   input  logic [NUM_T_PIPES-1:0]                 frag_fifo_empty,
   input  logic [NUM_T_PIPES-1:0]                 fifo_overflow,
   input  logic [NUM_T_PIPES-1:0]                 pipe_ready,
   input  logic [NUM_T_PIPES-1:0]                 pipe_done,
   output logic                                   lb_start,
   output logic                                   lb_abort,
   output logic [NUM_T_PIPES-1:0]                 pipe_start,
   output logic [NUM_T_PIPES-1:0]                 pipe_active,
   output logic                                   ready,
   output logic                                   done,
   output logic                                   aborted,
   output logic                                   err,
   output logic                                   cfg_no_perspective,
   output logic                                   cfg_flat,
   output logic                                   cfg_provoke_mode,
   output logic                                   cfg_winding_order,
   output logic                                   cfg_face_culler_enable,
   output logic                                   cfg_origin_location,
   output logic [1:0]                             cfg_mode,
   output logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] cfg_vertex_size,
   output logic [15:0]                            cfg_total_num_tris,
   output logic                                   cfg_poly_storage_structure,
   output logic [31:0]                            cfg_resx,
   output logic [31:0]                            cfg_resy,
   output logic [DATA_WIDTH-1:0]                  cfg_i_array_ptr,
   output logic [DATA_WIDTH-1:0]                  cfg_v_array_ptr,
   output logic [DATA_WIDTH-1:0]                  cfg_f_array_ptr,
   output logic [CNT_WIDTH-1:0]                   cycle_count,
   output logic [CNT_WIDTH-1:0]                   tri_launch_count
);
   localparam int W = LOCAL_VERTEX_MEM_ADDR_WIDTH;
   state_t state, nxt;
   logic [NUM_T_PIPES-1:0] mask, start_q, req;
   logic [W+7:0] c0;
   logic [POLY_BIT:0] c1;
   logic [15:0] resx, resy;
   logic go, busy, lb_seen, drained, flushed, unused;
   assign unused = ^{ctrl_reg0[DATA_WIDTH-1:W+8], ctrl_reg1[DATA_WIDTH-1:POLY_BIT+1]};
   assign busy = state == LAUNCH || state == RUN || state == DRAIN;
   assign go = en && state == IDLE && start;
   assign ready = state == IDLE;
   assign drained = lb_ready && &(tri_fifo_empty | ~mask) && &(frag_fifo_empty | ~mask)
                    && &(pipe_ready | ~mask) && !(|pipe_active) && !(|pipe_start);
   assign flushed = lb_ready && !(|pipe_active);
   assign cfg_no_perspective = c0[W+NO_PERSP_OFS];
   assign cfg_flat = c0[W+FLAT_OFS];
   assign cfg_provoke_mode = c0[W+PROVOKE_OFS];
   assign cfg_winding_order = c0[W+WINDING_OFS];
   assign cfg_face_culler_enable = c0[W+FACE_CULL_OFS];
   assign cfg_origin_location = c0[W+ORIGIN_OFS];
   assign cfg_mode = c0[W+MODE_OFS +: 2];
   assign cfg_vertex_size = c0[W-1:0];
   assign cfg_total_num_tris = c1[TRIS_MSB:0];
   assign cfg_poly_storage_structure = c1[POLY_BIT];
   assign cfg_resx = {16'b0, resx};
   assign cfg_resy = {16'b0, resy};
   rr_arbiter #(.N(NUM_T_PIPES)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (pipe_start)
   );
   always_comb begin
      nxt = state;
      lb_start = en && state == LAUNCH;
      lb_abort = en && abort && busy;
      // the previous-cycle start term blocks a regrant before pipe_active has caught up
      req = (en && !abort && (state == RUN || state == DRAIN))
            ? mask & pipe_ready & (tri_fifo_threshold | tri_fifo_full) & ~pipe_active & ~start_q : '0;
      if (en)
         case (state)
            IDLE:    nxt = start ? LAUNCH : IDLE;
            LAUNCH:  nxt = abort ? FLUSH : RUN;
            RUN:     nxt = abort ? FLUSH : (lb_done || lb_seen) ? DRAIN : RUN;
            DRAIN:   nxt = abort ? FLUSH : drained ? IDLE : DRAIN;
            FLUSH:   nxt = flushed ? IDLE : FLUSH;
            default: nxt = IDLE;
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         done <= 1'b0;
         aborted <= 1'b0;
         err <= 1'b0;
         lb_seen <= 1'b0;
         mask <= '0;
         start_q <= '0;
         pipe_active <= '0;
         cycle_count <= '0;
         tri_launch_count <= '0;
         c0 <= '0;
         c1 <= '0;
         resx <= '0;
         resy <= '0;
         cfg_i_array_ptr <= '0;
         cfg_v_array_ptr <= '0;
         cfg_f_array_ptr <= '0;
      end else begin
         state <= nxt;
         done <= state == DRAIN && nxt == IDLE;
         aborted <= state == FLUSH && nxt == IDLE;
         start_q <= pipe_start;
         if (en) pipe_active <= (pipe_active & ~pipe_done) | pipe_start;
         if (go) begin
            mask <= pipe_mask;
            c0 <= ctrl_reg0[W+7:0];
            c1 <= ctrl_reg1[POLY_BIT:0];
            resx <= res_reg[RESX_LSB +: 16];
            resy <= res_reg[15:0];
            cfg_i_array_ptr <= i_array_ptr;
            cfg_v_array_ptr <= v_array_ptr;
            cfg_f_array_ptr <= f_array_ptr;
            err <= 1'b0;
            lb_seen <= 1'b0;
            cycle_count <= '0;
            tri_launch_count <= '0;
         end else if (en) begin
            if (|(fifo_overflow & mask)) err <= 1'b1;
            if (lb_done && state != IDLE) lb_seen <= 1'b1;
            if (state != IDLE && !(&cycle_count)) cycle_count <= cycle_count + CNT_WIDTH'(1);
            if (|pipe_start && !(&tri_launch_count)) tri_launch_count <= tri_launch_count + CNT_WIDTH'(1);
         end
      end
endmodule

// File: doc/raster_job_ctrl.md
RASTER_JOB_CTRL -- requirements
Module: raster_job_ctrl

Interface
REQ-001 SHALL have parameter NUM_T_PIPES, default 4, number of triangle pipes controlled (1..16).
REQ-002 SHALL have parameter LOCAL_VERTEX_MEM_ADDR_WIDTH, default 4, width of the vertexSize field.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of the performance counters.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, width of the pointer and config words.
REQ-005 clk  in  1  sole clock; every register is rising-edge.
REQ-006 reset  in  1  asynchronous, active-high; one clock and asynchronous active-high reset, as already decided.
REQ-007 start, abort, en  in  1 each  job launch pulse; job kill pulse; global clock enable.
REQ-008 ctrl_reg0, ctrl_reg1, res_reg, i_array_ptr, v_array_ptr, f_array_ptr  in  DATA_WIDTH each  job descriptor, sampled on accepted start.
REQ-009 pipe_mask  in  NUM_T_PIPES  pipes enabled for this job, sampled on accepted start.
REQ-010 lb_ready, lb_done  in  1 each  load balancer idle; load balancer completion pulse.
REQ-011 tri_fifo_threshold, tri_fifo_full, tri_fifo_empty, frag_fifo_empty, fifo_overflow  in  NUM_T_PIPES each  per-pipe FIFO flags.
REQ-012 pipe_ready, pipe_done  in  NUM_T_PIPES each  per-pipe idle level; per-pipe completion pulse.
REQ-013 lb_start, lb_abort  out  1 each  one-cycle pulses to the load balancer.
REQ-014 pipe_start, pipe_active  out  NUM_T_PIPES each  one-cycle start pulses; per-pipe busy flags.
REQ-015 ready, done, aborted, err  out  1 each  idle level; completion pulse; abort-completion pulse; sticky overflow flag.
REQ-016 cfg_*  out  registered descriptor fields: noPerspective, flat, provokeMode, windingOrder, faceCullerEnable, origin_location, Mode[1:0], vertexSize, total_num_tris[15:0], poly_storage_structure, resx/resy (zero-extended to 32 bits), and the three pointers.
REQ-017 cycle_count, tri_launch_count  out  CNT_WIDTH each  cycles spent in the current/last job; pipe starts issued.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, RUN, DRAIN, FLUSH; all state changes SHALL occur only when en=1.
REQ-019 In IDLE with start=1, the block SHALL capture the descriptor and pipe_mask, clear both counters and err, and enter LAUNCH; start in any other state SHALL be ignored.
REQ-020 Descriptor fields SHALL be sliced as follows: ctrl_reg0[W+7..W] = noPerspective..Mode, with W = LOCAL_VERTEX_MEM_ADDR_WIDTH; ctrl_reg0[W-1:0] = vertexSize; ctrl_reg1[15:0] = total_num_tris; ctrl_reg1[16] = poly_storage_structure; res_reg[31:16] = resx; res_reg[15:0] = resy.
REQ-021 LAUNCH SHALL assert lb_start for exactly one cycle, then enter RUN; ready SHALL be 0 from the cycle after the accepted start.
REQ-022 In RUN and DRAIN, pipe p SHALL be eligible when mask[p], pipe_ready[p], (tri_fifo_threshold[p] or tri_fifo_full[p]), not pipe_active[p], and pipe_start[p] was 0 last cycle.
REQ-023 At most one pipe_start SHALL be issued per cycle, granted round-robin starting from the pipe after the last grant (pointer resets to 0); the grant SHALL set pipe_active[p] and increment tri_launch_count.
REQ-024 pipe_done[p] SHALL clear pipe_active[p]; a start and a done on the same pipe in the same cycle SHALL leave pipe_active[p]=1.
REQ-025 A lb_done pulse seen in RUN (or registered earlier) SHALL move the FSM to DRAIN.
REQ-026 DRAIN SHALL move to IDLE, pulsing done for one cycle and setting ready=1, when lb_ready=1, all masked tri_fifo_empty=1, all masked frag_fifo_empty=1, all masked pipe_ready=1, and pipe_active=0.
REQ-027 abort in LAUNCH, RUN or DRAIN SHALL pulse lb_abort, suppress further pipe_start, and enter FLUSH; FLUSH SHALL wait for pipe_active=0 and lb_ready=1, then pulse aborted (not done) and return to IDLE; abort in IDLE SHALL be ignored.
REQ-028 If abort and start are both 1 in IDLE, start SHALL win.
REQ-029 Any fifo_overflow bit, masked, SHALL set err, sticky until the next accepted start.
REQ-030 cycle_count SHALL increment every en=1 cycle outside IDLE and saturate at all-ones; tri_launch_count SHALL also saturate.
REQ-031 A pipe_mask of all zeros SHALL still run the load balancer, and done SHALL follow its completion under the DRAIN rules.

Reset
REQ-032 On reset: state=IDLE, ready=1; done, aborted, err, lb_start, lb_abort, pipe_start and pipe_active all 0; counters, cfg_* and the round-robin pointer 0.
REQ-033 Reset asserted mid-job SHALL return every output to its REQ-032 value asynchronously, and SHALL NOT pulse done or aborted.

Structure
REQ-034 The state enumeration and the ctrl_reg0/ctrl_reg1 bit-position constants SHALL live in the shared package raster_pkg.
REQ-035 The round-robin grant logic SHALL be the single sub-module rr_arbiter (request/grant vectors, pointer advance on grant).

Verification
REQ-036 NUM_T_PIPES=4, mask=4'b1111, start, pipes 0..3 eligible together -> pipe_start 0,1,2,3 on four consecutive cycles; tri_launch_count=4.
REQ-037 Job with total_num_tris=2: lb_done, then pipe_done for both pipes with FIFOs empty -> done for exactly 1 cycle, ready=1, cycle_count frozen.
REQ-038 Abort in RUN with pipe 2 active -> lb_abort pulse, no further pipe_start, aborted only after pipe_done[2], done never asserted.
REQ-039 Start and pipe_done on the same pipe in the same cycle -> pipe_active stays 1; a start arriving while not IDLE -> ignored, descriptor unchanged.
REQ-040 fifo_overflow[1] pulsed with mask bit 1=1 -> err=1 until the next start; the same pulse with mask bit 1=0 -> err stays 0.
REQ-041 Reset raised mid-DRAIN -> all outputs at REQ-032 values in the same cycle, with no done or aborted pulse.
